bram_stream_mc: RTL and testbench

- Instruction-driven BRAM stream buffer; parametrised successor of bram_stream_s.
- LOAD instructions write an AXI-Stream burst into a simple dual-port BRAM at a base address.
- READ instructions replay a window of it (base, length, repeat count) onto an output stream, with tlast per pass and sustained 1 beat/cycle.
- Sits between the DMA input streams and the systolic array operand ports.

---
 rtl/bram_stream_pkg.sv | 28 ++
 rtl/bram_stream_mc_bram_sdp.sv | 36 +++
 rtl/bram_stream_mc.sv | 253 +++++++++++++++++++++++++
 tb/tb_bram_stream_mc.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_stream_pkg.sv
// bram_stream_pkg: shared definitions for the bram_stream_mc buffer.
//   - Opcode constants for the 64-bit instruction word.
//   - Bit positions and widths of the instruction fields.
//   - FSM state encoding.
// Optional feature macro used by the top: BRAM_STREAM_PERF_EN.
package bram_stream_pkg;

    // Instruction layout: [63:62] op, [39:32] rep, [31:16] len, [15:0] base
    localparam int OP_MSB   = 63;
    localparam int OP_W     = 2;
    localparam int REP_LSB  = 32;
    localparam int REP_W    = 8;
    localparam int LEN_LSB  = 16;
    localparam int LEN_W    = 16;
    localparam int BASE_LSB = 0;
    localparam int BASE_W   = 16;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_READ = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        READ = 2'd2
    } state_t;

endpackage

// File: rtl/bram_stream_mc_bram_sdp.sv
// bram_sdp: simple dual-port RAM, one write port and one read port.
// Read data is registered (1-cycle latency) and only updates when rd_en is high.
// Contents are never cleared.
// Ports:
//   clk      clock
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_en    read strobe
//   rd_addr  read address
//   rd_data  registered read data
module bram_sdp #(
    parameter int DWIDTH = 1536,
    parameter int DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DWIDTH-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DWIDTH-1:0]        rd_data
);

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/bram_stream_mc.sv
// bram_stream_mc: instruction-driven BRAM stream buffer.
// LOAD instructions write an AXI-Stream burst into the BRAM at a base address;
// READ instructions replay a window (base, len, rep+1 passes) onto m_out with
// tlast at the end of every pass, at up to one beat per cycle.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   s_instruct_tdata/tvalid/tready    instruction stream
//   s_in_tdata/tvalid/tready/tlast    load data stream
//   m_out_tdata/tvalid/tready/tlast   replay stream
//   busy                              FSM active or output data still pending
//   err_len                           sticky load-length mismatch
//   perf_out_beats, perf_stall_cycles saturating counters when
//                                     BRAM_STREAM_PERF_EN is defined, else 0
module bram_stream_mc
    import bram_stream_pkg::*;
#(
    parameter int DWIDTH      = 1536,
    parameter int DEPTH       = 64,
    parameter int IWIDTH      = 64,
    parameter int OFIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IWIDTH-1:0] s_instruct_tdata,
    input  logic              s_instruct_tvalid,
    output logic              s_instruct_tready,
    input  logic [DWIDTH-1:0] s_in_tdata,
    input  logic              s_in_tvalid,
    output logic              s_in_tready,
    input  logic              s_in_tlast,
    output logic [DWIDTH-1:0] m_out_tdata,
    output logic              m_out_tvalid,
    input  logic              m_out_tready,
    output logic              m_out_tlast,
    output logic              busy,
    output logic              err_len,
    output logic [31:0]       perf_out_beats,
    output logic [31:0]       perf_stall_cycles
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int FPTR_W = $clog2(OFIFO_DEPTH);
    localparam int FCNT_W = $clog2(OFIFO_DEPTH + 1);

    // Instruction field decode
    logic [1:0]       ins_op;
    logic [REP_W-1:0] ins_rep;
    logic [LEN_W-1:0] ins_len;
    logic [ADDR_W-1:0] ins_base;
    logic             unused_ins_bits;

    assign ins_op   = s_instruct_tdata[OP_MSB -: OP_W];
    assign ins_rep  = s_instruct_tdata[REP_LSB +: REP_W];
    assign ins_len  = s_instruct_tdata[LEN_LSB +: LEN_W];
    assign ins_base = s_instruct_tdata[BASE_LSB +: ADDR_W];
    assign unused_ins_bits = ^{s_instruct_tdata[OP_MSB-OP_W:REP_LSB+REP_W],
                               s_instruct_tdata[BASE_LSB+BASE_W-1:BASE_LSB+ADDR_W]};

    // Control state
    state_t            state_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  idx_reg;
    logic [REP_W-1:0]  rep_reg;
    logic [REP_W-1:0]  pass_reg;
    logic              err_len_reg;

    // Read pipeline: issue register -> BRAM registered read -> FIFO
    logic              issue_v_reg;
    logic              issue_last_reg;
    logic [ADDR_W-1:0] issue_addr_reg;
    logic              bram_v_reg;
    logic              bram_last_reg;
    logic [DWIDTH-1:0] bram_rd_data;

    // Output FIFO
    logic [DWIDTH-1:0] fifo_data [OFIFO_DEPTH];
    logic              fifo_last [OFIFO_DEPTH];
    logic [FPTR_W-1:0] wr_ptr_reg;
    logic [FPTR_W-1:0] rd_ptr_reg;
    logic [FCNT_W-1:0] fifo_count_reg;

    logic [ADDR_W-1:0] cur_addr;
    logic              idx_last;
    logic              load_hs;
    logic              issue;
    logic              push;
    logic              pop;

    // ADDR_W-bit add wraps modulo DEPTH (DEPTH is a power of two)
    assign cur_addr = base_reg + idx_reg[ADDR_W-1:0];
    assign idx_last = (idx_reg == len_reg - LEN_W'(1));
    assign load_hs  = s_in_tvalid & s_in_tready;

    // Reserve FIFO space for beats already in the two pipeline stages so the
    // FIFO can never overflow, regardless of m_out_tready.
    assign issue = (state_reg == READ) &&
                   ((int'(fifo_count_reg) + int'(issue_v_reg) + int'(bram_v_reg)) < OFIFO_DEPTH);
    assign push  = bram_v_reg;
    assign pop   = (fifo_count_reg != '0) & m_out_tready;

    assign s_instruct_tready = (state_reg == IDLE);
    assign s_in_tready       = (state_reg == LOAD);

    bram_sdp #(
        .DWIDTH(DWIDTH),
        .DEPTH (DEPTH)
    ) u_bram (
        .clk    (clk),
        .wr_en  (load_hs),
        .wr_addr(cur_addr),
        .wr_data(s_in_tdata),
        .rd_en  (issue_v_reg),
        .rd_addr(issue_addr_reg),
        .rd_data(bram_rd_data)
    );

    // FSM plus read-issue stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            base_reg       <= '0;
            len_reg        <= '0;
            idx_reg        <= '0;
            rep_reg        <= '0;
            pass_reg       <= '0;
            err_len_reg    <= 1'b0;
            issue_v_reg    <= 1'b0;
            issue_last_reg <= 1'b0;
            issue_addr_reg <= '0;
        end else begin
            issue_v_reg <= issue;
            if (issue) begin
                issue_addr_reg <= cur_addr;
                issue_last_reg <= idx_last;
            end
            case (state_reg)
                IDLE: begin
                    if (s_instruct_tvalid) begin
                        base_reg <= ins_base;
                        len_reg  <= ins_len;
                        rep_reg  <= ins_rep;
                        idx_reg  <= '0;
                        pass_reg <= '0;
                        if (ins_len != '0) begin
                            if (ins_op == OP_LOAD) begin
                                state_reg <= LOAD;
                            end else if (ins_op == OP_READ) begin
                                state_reg <= READ;
                            end
                        end
                    end
                end
                LOAD: begin
                    if (load_hs) begin
                        idx_reg <= idx_reg + LEN_W'(1);
                        if (idx_last || s_in_tlast) begin
                            state_reg <= IDLE;
                            // Early tlast, or final beat without tlast
                            if (idx_last != s_in_tlast) begin
                                err_len_reg <= 1'b1;
                            end
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        if (idx_last) begin
                            idx_reg  <= '0;
                            pass_reg <= pass_reg + REP_W'(1);
                            if (pass_reg == rep_reg) begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            idx_reg <= idx_reg + LEN_W'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // BRAM output stage and FIFO bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_v_reg     <= 1'b0;
            bram_last_reg  <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            bram_v_reg <= issue_v_reg;
            if (issue_v_reg) begin
                bram_last_reg <= issue_last_reg;
            end
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == FPTR_W'(OFIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + FPTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == FPTR_W'(OFIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + FPTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + FCNT_W'(1);
                2'b01:   fifo_count_reg <= fifo_count_reg - FCNT_W'(1);
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    // FIFO storage needs no reset; validity is tracked by fifo_count_reg
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_reg] <= bram_rd_data;
            fifo_last[wr_ptr_reg] <= bram_last_reg;
        end
    end

    assign m_out_tvalid = (fifo_count_reg != '0);
    // Gate with tvalid so the outputs read 0 out of reset instead of stale storage
    assign m_out_tdata  = m_out_tvalid ? fifo_data[rd_ptr_reg] : '0;
    assign m_out_tlast  = m_out_tvalid & fifo_last[rd_ptr_reg];
    // Pipeline stages are included so busy stays high until the last beat
    // reaches the FIFO after the FSM has already returned to IDLE.
    assign busy    = (state_reg != IDLE) | m_out_tvalid | issue_v_reg | bram_v_reg;
    assign err_len = err_len_reg;

`ifdef BRAM_STREAM_PERF_EN
    logic [31:0] perf_beats_reg;
    logic [31:0] perf_stall_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_beats_reg <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (pop && (perf_beats_reg != 32'hFFFF_FFFF)) begin
                perf_beats_reg <= perf_beats_reg + 32'd1;
            end
            if (m_out_tvalid && !m_out_tready && (perf_stall_reg != 32'hFFFF_FFFF)) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_out_beats    = perf_beats_reg;
    assign perf_stall_cycles = perf_stall_reg;
`else
    assign perf_out_beats    = 32'd0;
    assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_bram_stream_mc.sv
// tb_bram_stream_mc: directed, table-driven bench for bram_stream_mc.
// Data beats carry a 32-bit key replicated (with per-slice salt) across the beat;
// a memory model of keys predicts every replayed beat.
module tb_bram_stream_mc;

    localparam int DW    = 1536;
    localparam int DEPTH = 64;
    localparam int OFD   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [63:0]   s_instruct_tdata = '0;
    logic          s_instruct_tvalid = 1'b0;
    logic          s_instruct_tready;
    logic [DW-1:0] s_in_tdata = '0;
    logic          s_in_tvalid = 1'b0;
    logic          s_in_tready;
    logic          s_in_tlast = 1'b0;
    logic [DW-1:0] m_out_tdata;
    logic          m_out_tvalid;
    logic          m_out_tready = 1'b1;
    logic          m_out_tlast;
    logic          busy;
    logic          err_len;
    logic [31:0]   perf_out_beats;
    logic [31:0]   perf_stall_cycles;

    always #5 clk = ~clk;

    bram_stream_mc #(
        .DWIDTH(DW), .DEPTH(DEPTH), .IWIDTH(64), .OFIFO_DEPTH(OFD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_instruct_tdata(s_instruct_tdata), .s_instruct_tvalid(s_instruct_tvalid),
        .s_instruct_tready(s_instruct_tready),
        .s_in_tdata(s_in_tdata), .s_in_tvalid(s_in_tvalid), .s_in_tready(s_in_tready),
        .s_in_tlast(s_in_tlast),
        .m_out_tdata(m_out_tdata), .m_out_tvalid(m_out_tvalid), .m_out_tready(m_out_tready),
        .m_out_tlast(m_out_tlast),
        .busy(busy), .err_len(err_len),
        .perf_out_beats(perf_out_beats), .perf_stall_cycles(perf_stall_cycles)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int model [DEPTH];
    int stall_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int key);
        logic [DW-1:0] d;
        for (int s = 0; s < DW/32; s++) d[s*32 +: 32] = 32'(key) ^ (32'(s) << 20);
        return d;
    endfunction

    function automatic int good_slices(input logic [DW-1:0] d, input int key);
        int g = 0;
        logic [DW-1:0] e;
        e = pat(key);
        for (int s = 0; s < DW/32; s++) if (d[s*32 +: 32] == e[s*32 +: 32]) g++;
        return g;
    endfunction

    // ---------------- output monitor (samples on negedge) ----------------
    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } beat_t;
    beat_t obs[$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_valid", 64'(m_out_tvalid), 64'd1);
                chk("stall_hold_data", 64'(m_out_tdata == prev_data), 64'd1);
                chk("stall_hold_last", 64'(m_out_tlast), 64'(prev_last));
            end
            if (m_out_tvalid && m_out_tready) begin
                beat_t b;
                b.data = m_out_tdata;
                b.last = m_out_tlast;
                b.cyc  = cyc;
                obs.push_back(b);
            end
            if (m_out_tvalid && !m_out_tready) begin
                stall_cnt++;
                prev_stall = 1'b1;
                prev_data  = m_out_tdata;
                prev_last  = m_out_tlast;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // ---------------- m_out_tready driver ----------------
    bit rand_ready = 1'b0;
    int run_left = 0;
    always @(posedge clk) begin
        #1;
        if (!rand_ready) begin
            m_out_tready = 1'b1;
        end else if (run_left == 0) begin
            m_out_tready = ~m_out_tready;
            run_left = $urandom_range(0, 7);
        end else begin
            run_left--;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_instr(input logic [1:0] op, input int rep, input int len, input int base,
                              output int hs);
        int n;
        s_instruct_tdata  = {op, 22'd0, 8'(rep), 16'(len), 16'(base)};
        s_instruct_tvalid = 1'b1;
        n = 0;
        while (!s_instruct_tready && n < 200) begin step(); n++; end
        if (!s_instruct_tready) chk("instr_ready_timeout", 64'd0, 64'd1);
        step();
        hs = cyc;
        s_instruct_tvalid = 1'b0;
    endtask

    // Offer nbeats beats; tlast on beat number tlast_beat (1-based, 0 = never)
    task automatic load(input int base, input int len, input int nbeats, input int tlast_beat,
                        input int key0);
        int hs, n;
        send_instr(2'b01, 0, len, base, hs);
        for (int b = 0; b < nbeats; b++) begin
            s_in_tdata  = pat(key0 + b);
            s_in_tlast  = (b + 1 == tlast_beat);
            s_in_tvalid = 1'b1;
            n = 0;
            while (!s_in_tready && n < 50) begin step(); n++; end
            if (!s_in_tready) begin
                chk("load_ready_timeout", 64'd0, 64'd1);
                break;
            end
            step();
            model[(base + b) % DEPTH] = key0 + b;
        end
        s_in_tvalid = 1'b0;
        s_in_tlast  = 1'b0;
        $display("load base=%0d len=%0d beats=%0d err_len=%0d", base, len, nbeats, err_len);
    endtask

    task automatic run_instr(input string name, input logic [1:0] op, input int base, input int len,
                             input int rep, input bit timed,
                             output int n_beats, output int first_key, output int final_key,
                             output int n_tlast);
        int hs, total, n;
        total = (op == 2'b10) ? len * (rep + 1) : 0;
        send_instr(op, rep, len, base, hs);
        if (total == 0) begin
            chk({name, "_consumed_ready"}, 64'(s_instruct_tready), 64'd1);
            chk({name, "_consumed_busy"}, 64'(busy), 64'd0);
        end
        n = 0;
        while (obs.size() < total && n < 4000) begin step(); n++; end
        n = 0;
        while (busy && n < 100) begin step(); n++; end
        chk({name, "_drained"}, 64'(busy), 64'd0);
        repeat (3) step();
        n_beats = obs.size();
        chk({name, "_beats"}, 64'(n_beats), 64'(total));
        first_key = 0;
        final_key = 0;
        n_tlast   = 0;
        for (int i = 0; i < n_beats && i < total; i++) begin
            int k;
            k = model[(base + i % len) % DEPTH];
            chk({name, "_key"}, 64'(obs[i].data[31:0]), 64'(k));
            chk({name, "_slices"}, 64'(good_slices(obs[i].data, k)), 64'(DW/32));
            chk({name, "_tlast"}, 64'(obs[i].last), 64'((i % len) == len - 1));
            if (timed) chk({name, "_cycle"}, 64'(obs[i].cyc), 64'(hs + 3 + i));
            if (obs[i].last) n_tlast++;
        end
        if (n_beats > 0) begin
            first_key = int'(obs[0].data[31:0]);
            final_key = int'(obs[n_beats-1].data[31:0]);
        end
        $display("instr %s op=%0d base=%0d len=%0d rep=%0d beats=%0d tlasts=%0d",
                 name, op, base, len, rep, n_beats, n_tlast);
        obs.delete();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        step();
        obs.delete();
        stall_cnt = 0;
        rst_n = 1'b1;
        step();
    endtask

    typedef struct {
        string      name;
        logic [1:0] op;
        int         base, len, rep;
        int         exp_beats, exp_first, exp_final, exp_tlasts;
    } vec_t;
    vec_t vecs [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, fk, lk, nt, n;

        // Hand-computed expectations, valid after words 0..63 hold keys 100+addr
        vecs[0] = '{"rd_0_8",      2'b10,  0, 8, 0,  8, 100, 107, 1};
        vecs[1] = '{"rd_wrap_60",  2'b10, 60, 8, 2, 24, 160, 103, 3};
        vecs[2] = '{"nop",         2'b00,  0, 8, 0,  0,   0,   0, 0};
        vecs[3] = '{"reserved",    2'b11,  0, 8, 0,  0,   0,   0, 0};
        vecs[4] = '{"rd_len0",     2'b10,  4, 0, 3,  0,   0,   0, 0};
        vecs[5] = '{"load_len0",   2'b01,  4, 0, 0,  0,   0,   0, 0};
        vecs[6] = '{"rd_wrap_62",  2'b10, 62, 3, 1,  6, 162, 100, 2};

        // ---------------- reset state ----------------
        repeat (3) step();
        chk("rst_tvalid", 64'(m_out_tvalid), 64'd0);
        chk("rst_tdata", 64'(m_out_tdata[63:0]), 64'd0);
        rst_n = 1'b1;
        step();
        chk("rst_instr_ready", 64'(s_instruct_tready), 64'd1);
        chk("rst_in_ready", 64'(s_in_tready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err_len", 64'(err_len), 64'd0);
        chk("rst_perf_beats", 64'(perf_out_beats), 64'd0);
        chk("rst_perf_stall", 64'(perf_stall_cycles), 64'd0);

        // ---------------- test 1: load 8 then replay with exact timing ----------------
        load(0, 8, 8, 8, 0);
        chk("t1_in_ready_after", 64'(s_in_tready), 64'd0);
        chk("t1_err_len", 64'(err_len), 64'd0);
        run_instr("t1_read", 2'b10, 0, 8, 0, 1'b1, nb, fk, lk, nt);
        chk("t1_first_key", 64'(fk), 64'd0);
        chk("t1_final_key", 64'(lk), 64'd7);
        chk("t1_tlasts", 64'(nt), 64'd1);

        // ---------------- fill all words, then the vector table ----------------
        load(0, 64, 64, 64, 100);
        chk("fill_err_len", 64'(err_len), 64'd0);
        for (int v = 0; v < 7; v++) begin
            run_instr(vecs[v].name, vecs[v].op, vecs[v].base, vecs[v].len, vecs[v].rep, 1'b1,
                      nb, fk, lk, nt);
            chk({vecs[v].name, "_tbl_beats"}, 64'(nb), 64'(vecs[v].exp_beats));
            chk({vecs[v].name, "_tbl_tlasts"}, 64'(nt), 64'(vecs[v].exp_tlasts));
            if (vecs[v].exp_beats > 0) begin
                chk({vecs[v].name, "_tbl_first"}, 64'(fk), 64'(vecs[v].exp_first));
                chk({vecs[v].name, "_tbl_final"}, 64'(lk), 64'(vecs[v].exp_final));
            end
        end

        // ---------------- test 3: random backpressure, 128 beats ----------------
        pulse_reset();
        rand_ready = 1'b1;
        run_instr("t3_backpressure", 2'b10, 0, 64, 1, 1'b0, nb, fk, lk, nt);
        rand_ready = 1'b0;
        step();
        chk("t3_tlasts", 64'(nt), 64'd2);
`ifdef BRAM_STREAM_PERF_EN
        chk("t3_perf_beats", 64'(perf_out_beats), 64'd128);
        chk("t3_perf_stall", 64'(perf_stall_cycles), 64'(stall_cnt));
`else
        chk("t3_perf_beats_off", 64'(perf_out_beats), 64'd0);
        chk("t3_perf_stall_off", 64'(perf_stall_cycles), 64'd0);
`endif
        $display("backpressure stall cycles=%0d", stall_cnt);

        // ---------------- test 4: early tlast, then missing tlast ----------------
        load(20, 8, 5, 5, 520);
        chk("t4_in_ready_after", 64'(s_in_tready), 64'd0);
        chk("t4_idle_ready", 64'(s_instruct_tready), 64'd1);
        chk("t4_err_len_early", 64'(err_len), 64'd1);
        load(40, 4, 4, 0, 540);
        chk("t4_err_len_sticky", 64'(err_len), 64'd1);

        // ---------------- test 5: reset in the middle of a READ ----------------
        send_instr(2'b10, 0, 32, 0, n);
        n = 0;
        while (obs.size() < 10 && n < 200) begin step(); n++; end
        chk("t5_pre_beats", 64'(obs.size() >= 10), 64'd1);
        for (int i = 0; i < 10 && i < obs.size(); i++)
            chk("t5_pre_key", 64'(obs[i].data[31:0]), 64'(model[i]));
        rst_n = 1'b0;
        #1;
        chk("t5_async_tvalid", 64'(m_out_tvalid), 64'd0);
        chk("t5_async_busy", 64'(busy), 64'd0);
        step();
        step();
        obs.delete();
        rst_n = 1'b1;
        step();
        chk("t5_instr_ready", 64'(s_instruct_tready), 64'd1);
        chk("t5_err_len_clear", 64'(err_len), 64'd0);
        chk("t5_no_output", 64'(obs.size()), 64'd0);
        run_instr("t5_after_reset", 2'b10, 18, 8, 0, 1'b1, nb, fk, lk, nt);
        chk("t5_first_key", 64'(fk), 64'd118);
        chk("t5_final_key", 64'(lk), 64'd125);

        // Missing tlast on its own must set err_len
        load(44, 4, 4, 0, 560);
        chk("t5_err_len_missing", 64'(err_len), 64'd1);
        run_instr("t5_readback", 2'b10, 40, 8, 0, 1'b1, nb, fk, lk, nt);
        chk("t5_rb_first", 64'(fk), 64'd540);
        chk("t5_rb_final", 64'(lk), 64'd563);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
